// File: rtl/cpu_types_pkg.sv
// Shared CPU execute types: ALU opcode encoding, vector ALU defaults and per-lane flag bundle.
// Encodings 4'd10..4'd15 are reserved; the vector ALU treats them as "produce nothing".
package cpu_types_pkg;

   typedef enum logic [3:0] {
      ALU_SLL  = 4'd0,
      ALU_SRL  = 4'd1,
      ALU_ADD  = 4'd2,
      ALU_SUB  = 4'd3,
      ALU_AND  = 4'd4,
      ALU_OR   = 4'd5,
      ALU_XOR  = 4'd6,
      ALU_NOR  = 4'd7,
      ALU_SLT  = 4'd8,
      ALU_SLTU = 4'd9
   } aluop_t;

   localparam int VALU_LANES_DEF  = 4;
   localparam int VALU_WORD_W_DEF = 32;
   localparam int VALU_TAG_W_DEF  = 5;

   typedef struct packed {
      logic nf;
      logic zf;
      logic of;
   } valu_flags_t;

endpackage

// File: rtl/vector_alu_pipe_if.sv
// Issue/result bundle of the vector ALU; slave = execute unit, master = issuer plus writeback.
// With VALU_SAT_EN the bundle also carries the per-request saturate bit in_sat.
interface vector_alu_pipe_if
   import cpu_types_pkg::*;
#(
   parameter int LANES  = VALU_LANES_DEF,
   parameter int WORD_W = VALU_WORD_W_DEF,
   parameter int TAG_W  = VALU_TAG_W_DEF
);
   logic                    in_valid;
   logic                    in_ready;
   aluop_t                  in_op;
   logic [LANES-1:0]        in_mask;
   logic [LANES*WORD_W-1:0] in_porta;
   logic [LANES*WORD_W-1:0] in_portb;
   logic [TAG_W-1:0]        in_tag;
`ifdef VALU_SAT_EN
   logic                    in_sat;
`endif
   logic                    out_valid;
   logic                    out_ready;
   logic [LANES*WORD_W-1:0] out_result;
   logic [LANES-1:0]        out_nf;
   logic [LANES-1:0]        out_zf;
   logic [LANES-1:0]        out_of;
   logic [LANES-1:0]        out_mask;
   logic [TAG_W-1:0]        out_tag;
   logic                    out_any_zf;
   logic                    out_all_zf;

   modport slave (
      input  in_valid, in_op, in_mask, in_porta, in_portb, in_tag,
`ifdef VALU_SAT_EN
      input  in_sat,
`endif
      output in_ready,
      output out_valid, out_result, out_nf, out_zf, out_of, out_mask, out_tag,
      output out_any_zf, out_all_zf,
      input  out_ready
   );

   modport master (
      output in_valid, in_op, in_mask, in_porta, in_portb, in_tag,
`ifdef VALU_SAT_EN
      output in_sat,
`endif
      input  in_ready,
      input  out_valid, out_result, out_nf, out_zf, out_of, out_mask, out_tag,
      input  out_any_zf, out_all_zf,
      output out_ready
   );

endinterface

// File: rtl/vector_alu_pipe_lane.sv
// valu_lane: one combinational ALU lane (op, A, B -> result, nf/zf/of); no state, no handshake.
// VALU_SAT_EN adds i_sat, which clamps overflowing ADD/SUB to the signed limit.
module valu_lane
   import cpu_types_pkg::*;
#(
   parameter int WORD_W = VALU_WORD_W_DEF
) (
   input  aluop_t            i_op,
   input  logic [WORD_W-1:0] i_a,
   input  logic [WORD_W-1:0] i_b,
`ifdef VALU_SAT_EN
   input  logic              i_sat,
`endif
   output logic [WORD_W-1:0] o_result,
   output valu_flags_t       o_flags
);
   localparam int SH_W = $clog2(WORD_W);
   localparam int MSB  = WORD_W - 1;

   logic [SH_W-1:0]   w_shamt;
   logic [WORD_W-1:0] w_sum;
   logic [WORD_W-1:0] w_diff;
   logic [WORD_W-1:0] w_raw;
   logic              w_of;
   logic              w_legal;

   assign w_shamt = i_b[SH_W-1:0];
   assign w_sum   = i_a + i_b;
   assign w_diff  = i_a - i_b;

   always_comb begin
      w_raw   = '0;
      w_of    = 1'b0;
      w_legal = 1'b1;
      case (i_op)
         ALU_SLL:  w_raw = i_a << w_shamt;
         ALU_SRL:  w_raw = i_a >> w_shamt;
         ALU_ADD: begin
            w_raw = w_sum;
            w_of  = (i_a[MSB] == i_b[MSB]) && (w_sum[MSB] != i_a[MSB]);
         end
         ALU_SUB: begin
            w_raw = w_diff;
            w_of  = (i_a[MSB] != i_b[MSB]) && (w_diff[MSB] != i_a[MSB]);
         end
         ALU_AND:  w_raw = i_a & i_b;
         ALU_OR:   w_raw = i_a | i_b;
         ALU_XOR:  w_raw = i_a ^ i_b;
         ALU_NOR:  w_raw = ~(i_a | i_b);
         ALU_SLT:  w_raw = {{(WORD_W-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
         ALU_SLTU: w_raw = {{(WORD_W-1){1'b0}}, (i_a < i_b)};
         default:  w_legal = 1'b0;
      endcase
   end

`ifdef VALU_SAT_EN
   // ADD and SUB can only overflow toward the sign opposite to A, so A's sign picks the limit.
   logic [WORD_W-1:0] w_sat_val;
   assign w_sat_val = i_a[MSB] ? {1'b1, {(WORD_W-1){1'b0}}} : {1'b0, {(WORD_W-1){1'b1}}};
   assign o_result  = (i_sat && w_of) ? w_sat_val : w_raw;
`else
   assign o_result  = w_raw;
`endif

   assign o_flags.nf = o_result[MSB];
   assign o_flags.zf = w_legal && (o_result == '0);
   assign o_flags.of = w_of;

endmodule

// File: rtl/vector_alu_pipe.sv
// LANES-wide SIMD ALU: stage A holds the request, stage B the masked results; out_valid one edge after accept.
// Each stage advances when empty or when the stage after it drains; VALU_SAT_EN adds a saturate bit.
module vector_alu_pipe
   import cpu_types_pkg::*;
#(
   parameter int LANES  = VALU_LANES_DEF,
   parameter int WORD_W = VALU_WORD_W_DEF,
   parameter int TAG_W  = VALU_TAG_W_DEF
) (
   input logic              CLK,
   input logic              nRST,
   vector_alu_pipe_if.slave bus
);
   logic                    r_va;
   aluop_t                  r_op;
   logic [LANES-1:0]        r_mask;
   logic [LANES*WORD_W-1:0] r_a;
   logic [LANES*WORD_W-1:0] r_b;
   logic [TAG_W-1:0]        r_tag;
`ifdef VALU_SAT_EN
   logic                    r_sat;
`endif

   logic                    r_vb;
   logic [LANES*WORD_W-1:0] r_res;
   logic [LANES-1:0]        r_nf;
   logic [LANES-1:0]        r_zf;
   logic [LANES-1:0]        r_of;
   logic [LANES-1:0]        r_mask_b;
   logic [TAG_W-1:0]        r_tag_b;
   logic                    r_any_zf;
   logic                    r_all_zf;

   logic                    w_rdy_a;
   logic                    w_rdy_b;
   logic                    w_fire_in;
   logic [LANES*WORD_W-1:0] w_res;
   logic [LANES-1:0]        w_nf;
   logic [LANES-1:0]        w_zf;
   logic [LANES-1:0]        w_of;
   logic                    w_any_zf;
   logic                    w_all_zf;

   assign w_rdy_b   = !r_vb || bus.out_ready;
   assign w_rdy_a   = !r_va || w_rdy_b;
   assign w_fire_in = bus.in_valid && w_rdy_a;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_va   <= 1'b0;
         r_op   <= ALU_SLL;
         r_mask <= '0;
         r_a    <= '0;
         r_b    <= '0;
         r_tag  <= '0;
`ifdef VALU_SAT_EN
         r_sat  <= 1'b0;
`endif
      end else begin
         if (w_rdy_a) begin
            r_va <= bus.in_valid;
         end
         if (w_fire_in) begin
            r_op   <= bus.in_op;
            r_mask <= bus.in_mask;
            r_a    <= bus.in_porta;
            r_b    <= bus.in_portb;
            r_tag  <= bus.in_tag;
`ifdef VALU_SAT_EN
            r_sat  <= bus.in_sat;
`endif
         end
      end
   end

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      logic [WORD_W-1:0] w_lane_res;
      valu_flags_t       w_lane_flags;

      valu_lane #(
         .WORD_W (WORD_W)
      ) u_lane (
         .i_op     (r_op),
         .i_a      (r_a[g*WORD_W +: WORD_W]),
         .i_b      (r_b[g*WORD_W +: WORD_W]),
`ifdef VALU_SAT_EN
         .i_sat    (r_sat),
`endif
         .o_result (w_lane_res),
         .o_flags  (w_lane_flags)
      );

      assign w_res[g*WORD_W +: WORD_W] = r_mask[g] ? w_lane_res : '0;
      assign w_nf[g] = r_mask[g] & w_lane_flags.nf;
      assign w_zf[g] = r_mask[g] & w_lane_flags.zf;
      assign w_of[g] = r_mask[g] & w_lane_flags.of;
   end

   // w_zf is already masked; inactive lanes count as "zero" for the all-reduction.
   assign w_any_zf = |w_zf;
   assign w_all_zf = (|r_mask) && (&(w_zf | ~r_mask));

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_vb     <= 1'b0;
         r_res    <= '0;
         r_nf     <= '0;
         r_zf     <= '0;
         r_of     <= '0;
         r_mask_b <= '0;
         r_tag_b  <= '0;
         r_any_zf <= 1'b0;
         r_all_zf <= 1'b0;
      end else if (w_rdy_b) begin
         r_vb <= r_va;
         if (r_va) begin
            r_res    <= w_res;
            r_nf     <= w_nf;
            r_zf     <= w_zf;
            r_of     <= w_of;
            r_mask_b <= r_mask;
            r_tag_b  <= r_tag;
            r_any_zf <= w_any_zf;
            r_all_zf <= w_all_zf;
         end
      end
   end

   assign bus.in_ready   = w_rdy_a;
   assign bus.out_valid  = r_vb;
   assign bus.out_result = r_res;
   assign bus.out_nf     = r_nf;
   assign bus.out_zf     = r_zf;
   assign bus.out_of     = r_of;
   assign bus.out_mask   = r_mask_b;
   assign bus.out_tag    = r_tag_b;
   assign bus.out_any_zf = r_any_zf;
   assign bus.out_all_zf = r_all_zf;

endmodule

// File: tb/tb_vector_alu_pipe.sv
// Scoreboard bench for vector_alu_pipe: issuer pushes model results, a negedge monitor pops and compares.
// Builds with or without VALU_SAT_EN.
module tb_vector_alu_pipe;
   import cpu_types_pkg::*;

   localparam int LANES  = 4;
   localparam int WORD_W = 32;
   localparam int TAG_W  = 5;
`ifdef VALU_SAT_EN
   localparam bit SAT_BUILT = 1'b1;
`else
   localparam bit SAT_BUILT = 1'b0;
`endif

   typedef struct {
      logic [127:0] res;
      logic [3:0]   nf;
      logic [3:0]   zf;
      logic [3:0]   ovf;
      logic [3:0]   mask;
      logic [4:0]   tag;
      logic         any_zf;
      logic         all_zf;
      int           acc;
      bit           lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   vector_alu_pipe_if #(.LANES(LANES), .WORD_W(WORD_W), .TAG_W(TAG_W)) bus ();

   vector_alu_pipe #(.LANES(LANES), .WORD_W(WORD_W), .TAG_W(TAG_W)) dut (
      .CLK  (clk),
      .nRST (rst_n),
      .bus  (bus)
   );

   int     n_chk = 0;
   int     n_fail = 0;
   int     edge_cnt = 0;
   exp_t   sb[$];
   bit     rdy_mode = 1'b0;
   logic   rdy_fix = 1'b1;
   logic [150:0] outs;
   logic [150:0] snap;
   bit     held = 1'b0;

   assign outs = {bus.out_result, bus.out_nf, bus.out_zf, bus.out_of, bus.out_mask,
                  bus.out_tag, bus.out_any_zf, bus.out_all_zf};

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   initial begin
      bus.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         bus.out_ready = rdy_mode ? ($urandom_range(0, 3) != 0) : rdy_fix;
      end
   end

   task automatic check(input string nm, input logic [150:0] act, input logic [150:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, req);
      end
   endtask

   // Reference: each lane computed with 64-bit signed arithmetic, then range-checked for overflow.
   function automatic exp_t model(input aluop_t op, input logic [3:0] mask, input logic [127:0] a,
                                  input logic [127:0] b, input logic [4:0] tag, input bit sat);
      exp_t e;
      logic [31:0] la, lb, r;
      longint sa, sbv, s;
      bit ok, ov, do_sat;
      do_sat = sat && SAT_BUILT;
      e.res = '0; e.nf = '0; e.zf = '0; e.ovf = '0;
      e.mask = mask; e.tag = tag; e.acc = 0; e.lat = 1'b0;
      for (int i = 0; i < LANES; i++) begin
         la = a[i*32 +: 32];
         lb = b[i*32 +: 32];
         sa = longint'($signed(la));
         sbv = longint'($signed(lb));
         ok = 1'b1; ov = 1'b0; r = '0; s = 0;
         case (op)
            ALU_SLL:  r = la << lb[4:0];
            ALU_SRL:  r = la >> lb[4:0];
            ALU_ADD, ALU_SUB: begin
               s = (op == ALU_ADD) ? sa + sbv : sa - sbv;
               r = s[31:0];
               ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
               if (ov && do_sat) r = (s > 0) ? 32'h7fffffff : 32'h80000000;
            end
            ALU_AND:  r = la & lb;
            ALU_OR:   r = la | lb;
            ALU_XOR:  r = la ^ lb;
            ALU_NOR:  r = ~(la | lb);
            ALU_SLT:  r = (sa < sbv) ? 32'd1 : 32'd0;
            ALU_SLTU: r = (la < lb) ? 32'd1 : 32'd0;
            default:  ok = 1'b0;
         endcase
         if (mask[i]) begin
            e.res[i*32 +: 32] = r;
            e.nf[i]  = r[31];
            e.zf[i]  = ok && (r == 32'd0);
            e.ovf[i] = ov;
         end
      end
      e.any_zf = |e.zf;
      e.all_zf = (mask != 4'd0) && ((e.zf & mask) == mask);
      return e;
   endfunction

   // Monitor: a transfer happens at the next edge whenever out_valid && out_ready here.
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         held = 1'b0;
      end else begin
         if (held) begin
            check("stall_valid", {150'd0, bus.out_valid}, 151'd1);
            check("stall_hold", outs, snap);
         end
         held = 1'b0;
         if (bus.out_valid) begin
            if (bus.out_ready) begin
               if (sb.size() == 0) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL unexpected_output: got tag %0d expected no output", bus.out_tag);
               end else begin
                  e = sb.pop_front();
                  check("result", {23'd0, bus.out_result}, {23'd0, e.res});
                  check("flags_nzo", {139'd0, bus.out_nf, bus.out_zf, bus.out_of},
                        {139'd0, e.nf, e.zf, e.ovf});
                  check("mask_tag", {142'd0, bus.out_mask, bus.out_tag}, {142'd0, e.mask, e.tag});
                  check("zf_reduce", {149'd0, bus.out_any_zf, bus.out_all_zf},
                        {149'd0, e.any_zf, e.all_zf});
                  if (e.lat) check("latency", 151'(edge_cnt), 151'(e.acc + 2));
               end
            end else begin
               held = 1'b1;
               snap = outs;
            end
         end
      end
   end

   // All main-thread activity sits 2 time units after a rising edge.
   task automatic issue(input aluop_t op, input logic [3:0] mask, input logic [127:0] a,
                        input logic [127:0] b, input logic [4:0] tag, input bit sat, input bit lat);
      exp_t e;
      int n;
      bit done;
      bus.in_valid = 1'b1;
      bus.in_op    = op;
      bus.in_mask  = mask;
      bus.in_porta = a;
      bus.in_portb = b;
      bus.in_tag   = tag;
`ifdef VALU_SAT_EN
      bus.in_sat   = sat;
`endif
      e = model(op, mask, a, b, tag, sat);
      e.lat = lat;
      done = 1'b0;
      n = 0;
      while (!done && n < 200) begin
         @(negedge clk);
         if (bus.in_ready) begin
            e.acc = edge_cnt;
            sb.push_back(e);
            done = 1'b1;
         end
         @(posedge clk);
         #2;
         n++;
      end
      bus.in_valid = 1'b0;
      if (!done) begin
         n_chk++;
         n_fail++;
         $display("FAIL issue_timeout: got no accept for tag %0d expected accept within 200 cycles", tag);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic set_rdy(input bit mode, input logic v);
      @(negedge clk);
      rdy_mode = mode;
      rdy_fix  = v;
      @(posedge clk);
      #2;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 1000) begin
         @(posedge clk);
         #2;
         n++;
      end
      check("drain_empty", 151'(sb.size()), 151'd0);
   endtask

   function automatic logic [31:0] rand_word();
      case ($urandom_range(0, 5))
         0: return 32'h0000_0000;
         1: return 32'h0000_0001;
         2: return 32'h7fff_ffff;
         3: return 32'h8000_0000;
         4: return 32'hffff_ffff;
         default: return $urandom;
      endcase
   endfunction

   function automatic logic [127:0] rand_vec();
      logic [127:0] v;
      for (int i = 0; i < LANES; i++) v[i*32 +: 32] = rand_word();
      return v;
   endfunction

   initial begin
      logic [127:0] va, vb;
      bus.in_valid = 1'b0;
      bus.in_op    = ALU_ADD;
      bus.in_mask  = '0;
      bus.in_porta = '0;
      bus.in_portb = '0;
      bus.in_tag   = '0;
`ifdef VALU_SAT_EN
      bus.in_sat   = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #2;
      check("rst_out_valid", {150'd0, bus.out_valid}, 151'd0);
      check("rst_outputs", outs, 151'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #2;
      check("post_rst_in_ready", {150'd0, bus.in_ready}, 151'd1);

      // Signed overflow on lane 0, with and without saturation request.
      va = rand_vec(); vb = rand_vec();
      va[31:0] = 32'h7fff_ffff; vb[31:0] = 32'h0000_0001;
      issue(ALU_ADD, 4'b1111, va, vb, 5'd1, 1'b0, 1'b0);
      issue(ALU_ADD, 4'b1111, va, vb, 5'd2, 1'b1, 1'b0);
      va = rand_vec();
      issue(ALU_SUB, 4'b0101, va, va, 5'd3, 1'b0, 1'b0);
      issue(ALU_SUB, 4'b0000, va, va, 5'd4, 1'b0, 1'b0);
      issue(ALU_SLT, 4'b1111, {4{32'hffff_ffff}}, {4{32'h0}}, 5'd5, 1'b0, 1'b0);
      issue(ALU_SLTU, 4'b1111, {4{32'hffff_ffff}}, {4{32'h0}}, 5'd6, 1'b0, 1'b0);
      issue(ALU_SLL, 4'b1111, {4{32'h1}}, {4{32'h23}}, 5'd7, 1'b0, 1'b0);
      issue(aluop_t'(4'd13), 4'b1111, rand_vec(), rand_vec(), 5'd8, 1'b0, 1'b0);
      wait_drain();

      // Back-to-back issue with a free consumer: one result per cycle, fixed latency.
      for (int t = 0; t < 8; t++)
         issue(aluop_t'($urandom_range(0, 9)), 4'($urandom), rand_vec(), rand_vec(), 5'(t), 1'b0, 1'b1);
      wait_drain();

      // Consumer stalled: two accepts fill both stages, then the input must close.
      set_rdy(1'b0, 1'b0);
      issue(ALU_XOR, 4'b1011, rand_vec(), rand_vec(), 5'd20, 1'b0, 1'b0);
      issue(ALU_NOR, 4'b1110, rand_vec(), rand_vec(), 5'd21, 1'b0, 1'b0);
      check("stall_in_ready", {150'd0, bus.in_ready}, 151'd0);
      idle(5);
      set_rdy(1'b0, 1'b1);
      wait_drain();

      // Reset with both stages occupied discards them.
      set_rdy(1'b0, 1'b0);
      issue(ALU_OR, 4'b1111, rand_vec(), rand_vec(), 5'd22, 1'b0, 1'b0);
      issue(ALU_AND, 4'b1111, rand_vec(), rand_vec(), 5'd23, 1'b0, 1'b0);
      check("full_out_valid", {150'd0, bus.out_valid}, 151'd1);
      rst_n = 1'b0;
      sb.delete();
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      #1;
      check("midrst_out_valid", {150'd0, bus.out_valid}, 151'd0);
      check("midrst_in_ready", {150'd0, bus.in_ready}, 151'd1);
      check("midrst_outputs", outs, 151'd0);
      set_rdy(1'b0, 1'b1);

      // Random traffic with random consumer backpressure.
      set_rdy(1'b1, 1'b1);
      for (int k = 0; k < 300; k++) begin
         va = rand_vec();
         vb = ($urandom_range(0, 4) == 0) ? va : rand_vec();
         issue(aluop_t'($urandom_range(0, 15)), 4'($urandom), va, vb, 5'($urandom),
               1'($urandom), 1'b0);
         if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
      end
      set_rdy(1'b0, 1'b1);
      wait_drain();
      idle(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/vector_alu_pipe.md
Name: vector_alu_pipe

Overview:
- Parametrised, pipelined successor to the scalar/vector ALU interface pair: LANES-wide SIMD/SIMT execute unit with one op broadcast to all lanes.
- Adds per-lane active mask, valid/ready handshake with backpressure, a fixed two-register pipeline, an issue tag, and mask-aware flag reduction.
- Sits between the vector register-read stage and vector writeback; the scalar path keeps the existing single ALU.

Parameters:
- LANES, 4, number of lanes (threads); must be ≥1.
- WORD_W, 32, lane data width; power of two, ≥8.
- TAG_W, 5, width of the opaque issue tag (e.g. destination register index).

Ports:
- CLK  in  1  clock.
- nRST  in  1  asynchronous active-low reset.
- in_valid  in  1  issue request.
- in_ready  out  1  unit can accept this cycle.
- in_op  in  aluop_t  operation for all lanes.
- in_mask  in  LANES  per-lane active bit.
- in_porta  in  LANES*WORD_W  lane operands A; lane i at [i*WORD_W +: WORD_W].
- in_portb  in  LANES*WORD_W  lane operands B, same packing.
- in_tag  in  TAG_W  carried unchanged to output.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_result  out  LANES*WORD_W  lane results.
- out_nf, out_zf, out_of  out  LANES each  per-lane negative, zero and signed-overflow flags.
- out_mask  out  LANES  registered copy of in_mask.
- out_tag  out  TAG_W  registered copy of in_tag.
- out_any_zf, out_all_zf  out  1 each  reductions of out_zf over active lanes.

Behaviour:
- Reset: all valid bits, data, flags, mask, tag and reductions reset to 0. in_ready reads 1 once nRST deasserts.
- Reset asserted mid-operation discards in-flight entries immediately; nothing is replayed.
- Stage A register: captures op, mask, operands and tag on an in_valid && in_ready edge.
- Stage B register: captures lane results, flags and reductions computed from stage A.
- Handshake:
  - rdyB = !vB || out_ready.
  - rdyA = !vA || rdyB.
  - in_ready = rdyA (combinational; no combinational path from in_valid).
- Latency: a request accepted on edge k has out_valid=1 after edge k+1. Throughput is 1 per cycle while out_ready=1.
- Stall: while out_valid && !out_ready, all out_* signals hold stable. Stage A is also held if occupied.
- Simultaneous B drain and A refill in the same edge is legal and incurs no bubble.
- Ops:
  - ALU_SLL/ALU_SRL shift A by B[log2(WORD_W)-1:0].
  - ALU_ADD and ALU_SUB wrap modulo 2^WORD_W.
  - ALU_AND, ALU_OR, ALU_XOR, ALU_NOR are bitwise.
  - ALU_SLT (signed) and ALU_SLTU (unsigned) return 1 or 0, zero-extended.
- Flags per lane: nf = result MSB; zf = (result==0).
  - of for ADD: operands have the same sign and the result sign differs.
  - of for SUB: operand signs differ and the result sign differs from A.
  - of = 0 for all other ops.
- Masked-off lane: result, nf, zf, of all 0.
- out_any_zf = OR(zf & mask).
- out_all_zf = (mask != 0) && AND(zf | ~mask). A mask of all zeros gives all_zf = 0.
- A request with mask == 0 is still accepted and emitted (the tag must reach writeback).
- Undefined op encoding: result 0, flags 0.

Optional Feature:
- Macro VALU_SAT_EN adds a 1-bit input in_sat, captured in stage A.
- With the macro and in_sat=1, ADD/SUB saturate to the signed max/min instead of wrapping; of still reports the pre-saturation overflow.
- Without the macro, the port is absent and ADD/SUB always wrap.

Decomposition:
- cpu_types_pkg holds aluop_t (already present). Add:
  - VALU_LANES_DEF and VALU_TAG_W_DEF constants;
  - a valu_flags_t struct {nf, zf, of}.
- One combinational sub-module, valu_lane, implements a single lane (op, A, B, sat → result, flags).
- vector_alu_pipe instantiates LANES copies of valu_lane via a generate loop and owns all registers, handshake and reductions.

Test Plan:
- Reset while both stages are valid → after release, out_valid=0, in_ready=1, all outputs 0.
- ADD, lane0 A=0x7FFFFFFF, B=1, mask=4'b1111 → lane0 result 0x80000000, of=1, nf=1. With VALU_SAT_EN and in_sat=1 → lane0 result 0x7FFFFFFF, of=1.
- SUB with A==B in all lanes, mask=4'b0101 → zf=4'b0101, any_zf=1, all_zf=1, lanes 1 and 3 result 0. Same ops with mask=0 → all_zf=0, tag still emitted.
- Back-to-back 8 issues with tags 0..7, out_ready=1 → outputs on 8 consecutive cycles, 2 edges after each accept, tags in order.
- Hold out_ready=0 for 5 cycles after two issues → in_ready drops after 2 accepts, outputs stay stable, no loss or duplication once released.
- SLT A=-1, B=0 → 1. SLTU A=0xFFFFFFFF, B=0 → 0. SLL A=1, B=0x23 → 0x8.
